// File: rtl/enc8_pkg.sv
// Shared types and helpers for the 8-to-3 request encoder.
// Optional feature macro: ROUND_ROBIN_EN (selects rotating search start).
package enc8_pkg;

  localparam int NREQ = 8;

  typedef logic [7:0] req_t;
  typedef logic [2:0] idx_t;

  // Search start after reset: the top index, so the first pick matches fixed priority.
  localparam idx_t PTR_RST = 3'd7;

  // One-hot mask for a 3-bit index.
  function automatic req_t onehot8(idx_t i);
    req_t r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_enc8_3.sv
// Combinational downward-searching priority encoder with wrap-around.
// The search visits start, start-1, ..., 0, 7, ... and reports the first set bit.
module prio_enc8_3
  import enc8_pkg::*;
(
  input  req_t vec,
  input  idx_t start,
  output idx_t idx,
  output logic any
);

  // Walk the eight positions from start downward; the first hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && vec[start - idx_t'(k)]) begin
        idx = start - idx_t'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder8_3.sv
// Sequential 8-to-3 request encoder.
// Requests are captured into a pending mask (when e=1) and served one index per
// accepted handshake. Handshake: valid=1 means out holds a pending index; the
// consumer takes it by raising ack in that cycle, and the bit is cleared at the
// next rising edge (a new request on the same bit in that cycle keeps it set).
// ack while valid=0 is ignored. out may change before acceptance if a higher
// priority request arrives.
// Optional feature macro: ROUND_ROBIN_EN -- rotate the search start past each
// granted index; when undefined, the highest pending index always wins.
module req_encoder8_3
  import enc8_pkg::*;
#(
  parameter int delay = 50  // simulation-only delay in ps; not modelled in this RTL
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] out,
  output logic       valid,
  output logic [7:0] pend,
  output logic       ovf
);

  // A negative delay has no meaning; the parameter otherwise carries no logic.
  if (delay < 0) begin : g_neg_delay_ignored
  end

  req_t pend_q, pend_d;
  logic ovf_q, ovf_d;
  req_t set, clr;
  logic grant;
  idx_t sel_idx;
  idx_t start;
  logic sel_any;

`ifdef ROUND_ROBIN_EN
  idx_t ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = PTR_RST;
`endif

  prio_enc8_3 u_prio (
    .vec   (pend_q),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  assign valid = sel_any;
  assign out   = sel_any ? sel_idx : 3'd0;
  assign pend  = pend_q;
  assign ovf   = ovf_q;

  // Next-state: clear the granted bit, merge new requests, flag merges as overflow.
  always_comb begin
    grant  = sel_any & ack;
    clr    = grant ? onehot8(sel_idx) : '0;
    set    = e ? req : '0;
    pend_d = (pend_q & ~clr) | set;
    ovf_d  = ovf_q | (|(set & pend_q & ~clr));
`ifdef ROUND_ROBIN_EN
    ptr_d  = grant ? (sel_idx - 3'd1) : ptr_q;
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q  <= PTR_RST;
`endif
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
`ifdef ROUND_ROBIN_EN
      ptr_q  <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_req_encoder8_3.sv
// Self-checking bench for req_encoder8_3: directed scenarios plus random traffic
// compared against a behavioural model of the pending set.
module tb_req_encoder8_3;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [7:0] req;
  logic       ack;
  logic [2:0] out;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: pending flags, sticky overflow, round-robin start index.
  bit m_pend [8];
  bit m_ovf;
  int m_ptr;

  req_encoder8_3 #(.delay(50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .e     (e),
    .req   (req),
    .ack   (ack),
    .out   (out),
    .valid (valid),
    .pend  (pend),
    .ovf   (ovf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++) if (m_pend[i]) m = m + 8'(1 << i);
    return m;
  endfunction

  // Index the model would serve: highest pending index, or in round-robin
  // mode the first pending index met going down from the pointer.
  function automatic int m_sel();
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < 8; k++) if (m_pend[(m_ptr - k + 8) % 8]) return (m_ptr - k + 8) % 8;
`else
    for (int i = 7; i >= 0; i--) if (m_pend[i]) return i;
`endif
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
    m_ovf = 0;
    m_ptr = 7;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(m_count() != 0));
    check({tag, ".out"},   32'(out),   32'(m_count() != 0 ? m_sel() : 0));
    check({tag, ".pend"},  32'(pend),  32'(m_mask()));
    check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
  endtask

  // Drive one clock cycle from a falling edge and check the result at the next one.
  task automatic cycle(input logic e_v, input logic [7:0] req_v, input logic ack_v, input string tag);
    int  s;
    bit  granted;
    e = e_v; req = req_v; ack = ack_v;
    granted = (m_count() != 0) && ack_v;
    s = m_sel();
    if (granted) m_pend[s] = 0;
    for (int i = 0; i < 8; i++) begin
      if (e_v && req_v[i]) begin
        if (m_pend[i]) m_ovf = 1;
        m_pend[i] = 1;
      end
    end
    if (granted) m_ptr = (s + 7) % 8;
    @(posedge clk);
    @(negedge clk);
    e = 1'b0; req = 8'h00; ack = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    m_reset();
    check_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 16 && m_count() != 0; n++) cycle(1'b0, 8'h00, 1'b1, tag);
    check({tag, ".empty"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; e = 1'b0; req = 8'h00; ack = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_state("por");
    rst_n = 1'b1;

    // Fixed priority drain of 8'h91: 7, 4, 0, then empty.
    cycle(1'b1, 8'h91, 1'b0, "load91");
    check("drain91.first", 32'(out), 32'd7);
    cycle(1'b0, 8'h00, 1'b1, "drain91");
    check("drain91.second", 32'(out), 32'd4);
    cycle(1'b0, 8'h00, 1'b1, "drain91");
    check("drain91.third", 32'(out), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, "drain91");
    check("drain91.valid", 32'(valid), 32'd0);

    // ack with nothing pending is ignored.
    cycle(1'b0, 8'h00, 1'b1, "idle_ack");

    // Set beats clear on the same bit: no overflow.
    cycle(1'b1, 8'h08, 1'b0, "load08");
    cycle(1'b1, 8'h08, 1'b1, "set_over_clr");
    check("soc.pend", 32'(pend), 32'h08);
    check("soc.ovf", 32'(ovf), 32'd0);
    drain("soc_drain");

    // Enable gating: requests ignored with e=0; service continues.
    cycle(1'b1, 8'h01, 1'b0, "load01");
    cycle(1'b0, 8'hFF, 1'b0, "gate");
    check("gate.pend", 32'(pend), 32'h01);
    check("gate.out", 32'(out), 32'd0);
    cycle(1'b0, 8'hFF, 1'b1, "gate_ack");
    check("gate.valid", 32'(valid), 32'd0);

    // Overflow is sticky through drains.
    cycle(1'b1, 8'h02, 1'b0, "load02");
    cycle(1'b1, 8'h02, 1'b0, "merge02");
    check("ovf.set", 32'(ovf), 32'd1);
    cycle(1'b1, 8'hC4, 1'b0, "more");
    drain("ovf_drain");
    check("ovf.sticky", 32'(ovf), 32'd1);
    do_reset("ovf_reset");

    // Full mask: further requests only raise ovf.
    cycle(1'b1, 8'hFF, 1'b0, "fill");
    cycle(1'b1, 8'h10, 1'b0, "full_req");
    check("full.pend", 32'(pend), 32'hFF);
    check("full.ovf", 32'(ovf), 32'd1);
    drain("full_drain");
    do_reset("full_reset");

    // Repeated top request with bit 0 pending.
    cycle(1'b1, 8'h81, 1'b0, "load81");
    for (int i = 0; i < 4; i++) begin
`ifdef ROUND_ROBIN_EN
      check("rr.out", 32'(out), 32'(m_sel()));
`else
      check("fixed.starve", 32'(out), 32'd7);
`endif
      cycle(1'b1, 8'h80, 1'b1, "rr");
    end
    drain("rr_drain");
    do_reset("rr_reset");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 1)), r, ($urandom_range(0, 3) != 0), "rand");
    end

    // Asynchronous reset mid-stream with pend=8'h5A and a handshake in flight.
    drain("pre5a");
    cycle(1'b1, 8'h5A, 1'b0, "load5a");
    check("pre5a.pend", 32'(pend), 32'h5A);
    #3;
    ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst.pend", 32'(pend), 32'h00);
    check("arst.valid", 32'(valid), 32'd0);
    check("arst.out", 32'(out), 32'd0);
    check("arst.ovf", 32'(ovf), 32'd0);
    ack = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
